// File: rtl/soc_onchip_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip memory.
// Macro SOC_ONCHIP_MEM_OUTREG_EN adds an output register stage (read latency 2).
package soc_onchip_mem_pkg;

    typedef enum logic {
        PRI_S1 = 1'b0,
        PRI_S2 = 1'b1
    } pri_e;

`ifdef SOC_ONCHIP_MEM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Widest data word the merge helper handles; callers zero-extend into it.
    localparam int MERGE_W = 1024;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/soc_onchip_mem_ram_core.sv
// Inferred true dual-port, byte-enabled RAM with synchronous read-old-data
// behaviour. No reset on the array.
// The enclosing top never lets both ports write the same word in one cycle.
module soc_onchip_mem_ram_core #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 16384,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [DATA_W-1:0]   wdata_a,
    output logic [DATA_W-1:0]   q_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [DATA_W-1:0]   wdata_b,
    output logic [DATA_W-1:0]   q_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports read the old word and write enabled byte lanes on the same edge.
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        for (int i = 0; i < DATA_W/8; i++) begin
            if (we_a && be_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            if (we_b && be_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
        end
    end

endmodule

// File: rtl/soc_system_onchip_mem_dp.sv
// Dual Avalon-MM slave wrapper around the true dual-port RAM: range check,
// write-collision arbitration, read-during-write forwarding and the
// readdata/readdatavalid pipeline. Macro SOC_ONCHIP_MEM_OUTREG_EN adds an
// extra output register stage on both ports.
module soc_system_onchip_mem_dp
    import soc_onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 16384,
    parameter int    ADDR_W    = $clog2(DEPTH),
    parameter string INIT_FILE = "soc_system_onchip_mem_dp.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    input  logic [ADDR_W-1:0]   address2,
    input  logic                chipselect2,
    input  logic                read2,
    input  logic                write2,
    input  logic [DATA_W/8-1:0] byteenable2,
    input  logic [DATA_W-1:0]   writedata2,
    output logic [DATA_W-1:0]   readdata2,
    output logic                readdatavalid2,
    output logic                waitrequest2
);

    localparam int NB = DATA_W/8;

    pri_e pri;

    logic              in_range1, in_range2;
    logic              wr_req1, wr_req2;
    logic              collision;
    logic              we1, we2;
    logic              acc_rd1, acc_rd2;
    logic              fwd1, fwd2;
    logic [DATA_W-1:0] ram_q1, ram_q2;

    logic              rd_v1_q, rd_v2_q;
    logic              oor1_q, oor2_q;
    logic              fwd1_q, fwd2_q;
    logic [DATA_W-1:0] fwd_data1_q, fwd_data2_q;
    logic [NB-1:0]     fwd_be1_q, fwd_be2_q;
    logic [DATA_W-1:0] data1, data2;

    assign in_range1 = {1'b0, address}  < (ADDR_W+1)'(DEPTH);
    assign in_range2 = {1'b0, address2} < (ADDR_W+1)'(DEPTH);

    assign wr_req1 = chipselect  & write;
    assign wr_req2 = chipselect2 & write2;

    assign collision    = wr_req1 & wr_req2 & in_range1 & in_range2 & (address == address2);
    assign waitrequest  = collision & (pri == PRI_S2);
    assign waitrequest2 = collision & (pri == PRI_S1);

    assign we1 = wr_req1 & ~waitrequest  & in_range1;
    assign we2 = wr_req2 & ~waitrequest2 & in_range2;

    assign acc_rd1 = chipselect  & read  & ~write;
    assign acc_rd2 = chipselect2 & read2 & ~write2;

    assign fwd1 = acc_rd1 & we2 & (address  == address2);
    assign fwd2 = acc_rd2 & we1 & (address2 == address);

    soc_onchip_mem_ram_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .addr_a  (address),
        .we_a    (we1),
        .be_a    (byteenable),
        .wdata_a (writedata),
        .q_a     (ram_q1),
        .addr_b  (address2),
        .we_b    (we2),
        .be_b    (byteenable2),
        .wdata_b (writedata2),
        .q_b     (ram_q2)
    );

    // Collision priority flips only when a collision is actually arbitrated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri <= PRI_S1;
        end else if (collision) begin
            pri <= (pri == PRI_S1) ? PRI_S2 : PRI_S1;
        end
    end

    // Capture read qualifiers and other-port write data alongside the RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            oor1_q      <= 1'b0;
            oor2_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd_data1_q <= '0;
            fwd_data2_q <= '0;
            fwd_be1_q   <= '0;
            fwd_be2_q   <= '0;
        end else begin
            rd_v1_q     <= acc_rd1;
            rd_v2_q     <= acc_rd2;
            oor1_q      <= ~in_range1;
            oor2_q      <= ~in_range2;
            fwd1_q      <= fwd1;
            fwd2_q      <= fwd2;
            fwd_data1_q <= writedata2;
            fwd_data2_q <= writedata;
            fwd_be1_q   <= byteenable2;
            fwd_be2_q   <= byteenable;
        end
    end

    // Form the returned word: zero when idle or out of range, else RAM data
    // with the other port's same-cycle write merged over it.
    always_comb begin
        data1 = '0;
        data2 = '0;
        if (rd_v1_q && !oor1_q) begin
            if (fwd1_q)
                data1 = DATA_W'(be_merge(MERGE_W'(ram_q1), MERGE_W'(fwd_data1_q), (MERGE_W/8)'(fwd_be1_q)));
            else
                data1 = ram_q1;
        end
        if (rd_v2_q && !oor2_q) begin
            if (fwd2_q)
                data2 = DATA_W'(be_merge(MERGE_W'(ram_q2), MERGE_W'(fwd_data2_q), (MERGE_W/8)'(fwd_be2_q)));
            else
                data2 = ram_q2;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_outreg
            logic [DATA_W-1:0] rdata1_q, rdata2_q;
            logic              v1_q, v2_q;

            // Extra output stage carrying data and valid one more cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata1_q <= '0;
                    rdata2_q <= '0;
                    v1_q     <= 1'b0;
                    v2_q     <= 1'b0;
                end else begin
                    rdata1_q <= data1;
                    rdata2_q <= data2;
                    v1_q     <= rd_v1_q;
                    v2_q     <= rd_v2_q;
                end
            end

            assign readdata       = rdata1_q;
            assign readdata2      = rdata2_q;
            assign readdatavalid  = v1_q;
            assign readdatavalid2 = v2_q;
        end else begin : g_direct
            assign readdata       = data1;
            assign readdata2      = data2;
            assign readdatavalid  = rd_v1_q;
            assign readdatavalid2 = rd_v2_q;
        end
    endgenerate

endmodule

// File: tb/tb_soc_system_onchip_mem_dp.sv
// Self-checking bench for soc_system_onchip_mem_dp (DEPTH=1000 to exercise
// the range check). Works with or without SOC_ONCHIP_MEM_OUTREG_EN.
module tb_soc_system_onchip_mem_dp;
    import soc_onchip_mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] a1, a2;
    logic              cs1, rd1, wr1, cs2, rd2, wr2;
    logic [3:0]        be1, be2;
    logic [31:0]       wd1, wd2;
    logic [31:0]       rdata1, rdata2;
    logic              rvalid1, rvalid2, wait1, wait2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        cs1, rd1, wr1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        cs2, rd2, wr2;
        logic [9:0]  a2;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic        ew1, ew2;
        logic        ev1;
        logic [31:0] ed1;
        logic        ev2;
        logic [31:0] ed2;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    soc_system_onchip_mem_dp #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (a1),
        .chipselect     (cs1),
        .read           (rd1),
        .write          (wr1),
        .byteenable     (be1),
        .writedata      (wd1),
        .readdata       (rdata1),
        .readdatavalid  (rvalid1),
        .waitrequest    (wait1),
        .address2       (a2),
        .chipselect2    (cs2),
        .read2          (rd2),
        .write2         (wr2),
        .byteenable2    (be2),
        .writedata2     (wd2),
        .readdata2      (rdata2),
        .readdatavalid2 (rvalid2),
        .waitrequest2   (wait2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        cs1 = 0; rd1 = 0; wr1 = 0; a1 = '0; be1 = '0; wd1 = '0;
        cs2 = 0; rd2 = 0; wr2 = 0; a2 = '0; be2 = '0; wd2 = '0;
    endtask

    // One command cycle, then wait out the read latency and check returns.
    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        cs1 = v.cs1; rd1 = v.rd1; wr1 = v.wr1; a1 = v.a1; be1 = v.be1; wd1 = v.wd1;
        cs2 = v.cs2; rd2 = v.rd2; wr2 = v.wr2; a2 = v.a2; be2 = v.be2; wd2 = v.wd2;
        #1;
        checkOutput($sformatf("vec%0d.wait1", idx), {31'b0, wait1}, {31'b0, v.ew1});
        checkOutput($sformatf("vec%0d.wait2", idx), {31'b0, wait2}, {31'b0, v.ew2});
        @(posedge clk); #1;
        driveIdle();
        for (int k = 1; k <= RD_LAT; k++) begin
            if (k == RD_LAT) begin
                checkOutput($sformatf("vec%0d.valid1", idx), {31'b0, rvalid1}, {31'b0, v.ev1});
                checkOutput($sformatf("vec%0d.valid2", idx), {31'b0, rvalid2}, {31'b0, v.ev2});
                if (v.ev1) checkOutput($sformatf("vec%0d.rdata1", idx), rdata1, v.ed1);
                if (v.ev2) checkOutput($sformatf("vec%0d.rdata2", idx), rdata2, v.ed2);
            end else begin
                checkOutput($sformatf("vec%0d.early_valid1", idx), {31'b0, rvalid1}, 32'd0);
                checkOutput($sformatf("vec%0d.early_valid2", idx), {31'b0, rvalid2}, 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0]  ra1 [3];
        logic [9:0]  ra2 [3];
        logic [31:0] re1 [3];
        logic [31:0] re2 [3];
        logic [31:0] cw1 [3];
        logic [31:0] cw2 [3];
        int jr;

        //            cs1 rd1 wr1 a1        be1   wd1           cs2 rd2 wr2 a2        be2   wd2           ew1 ew2 ev1 ed1           ev2 ed2
        vecs[0]  = '{1, 0, 1, 10'h010, 4'hF, 32'hDEADBEEF, 0, 0, 0, 10'h000, 4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[1]  = '{0, 0, 0, 10'h000, 4'h0, 32'h0,        1, 1, 0, 10'h010, 4'h0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 1, 10'h010, 4'h1, 32'h000000AA, 0, 0, 0, 10'h000, 4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[3]  = '{1, 1, 0, 10'h010, 4'h0, 32'h0,        0, 0, 0, 10'h000, 4'h0, 32'h0,        0, 0, 1, 32'hDEADBEAA, 0, 32'h0};
        vecs[4]  = '{0, 0, 0, 10'h000, 4'h0, 32'h0,        1, 0, 1, 10'h030, 4'hF, 32'h12345678, 0, 0, 0, 32'h0,        0, 32'h0};
        vecs[5]  = '{1, 0, 1, 10'h030, 4'hC, 32'hCAFEF00D, 1, 1, 0, 10'h030, 4'h0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hCAFE5678};
        vecs[6]  = '{1, 1, 0, 10'h030, 4'h0, 32'h0,        0, 0, 0, 10'h000, 4'h0, 32'h0,        0, 0, 1, 32'hCAFE5678, 0, 32'h0};
        vecs[7]  = '{1, 1, 0, 10'h030, 4'h0, 32'h0,        1, 0, 1, 10'h030, 4'h0, 32'hFFFFFFFF, 0, 0, 1, 32'hCAFE5678, 0, 32'h0};
        vecs[8]  = '{1, 0, 1, 10'd999, 4'hF, 32'hA5A5A5A5, 1, 0, 1, 10'd1000,4'hF, 32'h12345678, 0, 0, 0, 32'h0,        0, 32'h0};
        vecs[9]  = '{1, 1, 0, 10'd1000,4'h0, 32'h0,        1, 1, 0, 10'd999, 4'h0, 32'h0,        0, 0, 1, 32'h0,        1, 32'hA5A5A5A5};
        vecs[10] = '{1, 1, 1, 10'h040, 4'hF, 32'h55667788, 0, 0, 0, 10'h000, 4'h0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[11] = '{1, 1, 0, 10'h010, 4'h0, 32'h0,        1, 1, 0, 10'h040, 4'h0, 32'h0,        0, 0, 1, 32'hDEADBEAA, 1, 32'h55667788};
        vecs[12] = '{1, 0, 1, 10'd1000,4'hF, 32'h11223344, 1, 0, 1, 10'd1000,4'hF, 32'h55667788, 0, 0, 0, 32'h0,        0, 32'h0};
        vecs[13] = '{0, 1, 0, 10'h010, 4'h0, 32'h0,        0, 0, 1, 10'h010, 4'hF, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        vecs[14] = '{0, 0, 0, 10'h000, 4'h0, 32'h0,        1, 1, 0, 10'h010, 4'h0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hDEADBEAA};

        ra1 = '{10'h010, 10'h030, 10'd999};
        re1 = '{32'hDEADBEAA, 32'hCAFE5678, 32'hA5A5A5A5};
        ra2 = '{10'h040, 10'h020, 10'd1000};
        re2 = '{32'h55667788, 32'h11111111, 32'h00000000};
        cw1 = '{32'd0, 32'd1, 32'd0};
        cw2 = '{32'd1, 32'd0, 32'd1};

        // Reset state
        driveIdle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.valid1", {31'b0, rvalid1}, 32'd0);
        checkOutput("reset.valid2", {31'b0, rvalid2}, 32'd0);
        checkOutput("reset.rdata1", rdata1, 32'd0);
        checkOutput("reset.rdata2", rdata2, 32'd0);
        checkOutput("reset.wait1",  {31'b0, wait1}, 32'd0);
        checkOutput("reset.wait2",  {31'b0, wait2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // s1 write then s2 read on the very next cycle
        @(negedge clk);
        cs1 = 1; wr1 = 1; a1 = 10'h010; be1 = 4'hF; wd1 = 32'hDEADBEEF;
        @(posedge clk); #1;
        driveIdle();
        @(negedge clk);
        cs2 = 1; rd2 = 1; a2 = 10'h010;
        @(posedge clk); #1;
        driveIdle();
        repeat (RD_LAT - 1) begin
            checkOutput("b2b.early_valid2", {31'b0, rvalid2}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("b2b.valid2", {31'b0, rvalid2}, 32'd1);
        checkOutput("b2b.rdata2", rdata2, 32'hDEADBEEF);
        @(posedge clk); #1;
        checkOutput("b2b.valid2_one_pulse", {31'b0, rvalid2}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 15; i++) applyStimulus(i, vecs[i]);

        // Three-cycle held write collision at 0x20
        @(negedge clk);
        cs1 = 1; wr1 = 1; a1 = 10'h020; be1 = 4'hF; wd1 = 32'h11111111;
        cs2 = 1; wr2 = 1; a2 = 10'h020; be2 = 4'hF; wd2 = 32'h22222222;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("coll%0d.wait1", c), {31'b0, wait1}, cw1[c]);
            checkOutput($sformatf("coll%0d.wait2", c), {31'b0, wait2}, cw2[c]);
            @(posedge clk);
            @(negedge clk);
        end
        driveIdle();
        cs2 = 1; rd2 = 1; a2 = 10'h020;
        @(posedge clk); #1;
        driveIdle();
        repeat (RD_LAT - 1) @(posedge clk);
        #1;
        checkOutput("coll.valid2", {31'b0, rvalid2}, 32'd1);
        checkOutput("coll.rdata2", rdata2, 32'h11111111);

        // Pipelined reads on both ports, then reset while returns are in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            driveIdle();
            cs1 = 1; rd1 = 1; a1 = ra1[k];
            cs2 = 1; rd2 = 1; a2 = ra2[k];
            @(posedge clk); #1;
            jr = k - (RD_LAT - 1);
            if (jr >= 0) begin
                checkOutput($sformatf("pipe%0d.valid1", jr), {31'b0, rvalid1}, 32'd1);
                checkOutput($sformatf("pipe%0d.rdata1", jr), rdata1, re1[jr]);
                checkOutput($sformatf("pipe%0d.valid2", jr), {31'b0, rvalid2}, 32'd1);
                checkOutput($sformatf("pipe%0d.rdata2", jr), rdata2, re2[jr]);
            end else begin
                checkOutput("pipe.early_valid1", {31'b0, rvalid1}, 32'd0);
                checkOutput("pipe.early_valid2", {31'b0, rvalid2}, 32'd0);
            end
        end
        @(negedge clk);
        driveIdle();
        reset = 1'b1;
        #1;
        checkOutput("squash.valid1", {31'b0, rvalid1}, 32'd0);
        checkOutput("squash.valid2", {31'b0, rvalid2}, 32'd0);
        checkOutput("squash.rdata1", rdata1, 32'd0);
        checkOutput("squash.rdata2", rdata2, 32'd0);
        checkOutput("squash.wait1",  {31'b0, wait1}, 32'd0);
        checkOutput("squash.wait2",  {31'b0, wait2}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("inreset.valid1", {31'b0, rvalid1}, 32'd0);
            checkOutput("inreset.valid2", {31'b0, rvalid2}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("postreset.valid1", {31'b0, rvalid1}, 32'd0);
            checkOutput("postreset.valid2", {31'b0, rvalid2}, 32'd0);
        end

        // Memory contents survive reset
        @(negedge clk);
        cs1 = 1; rd1 = 1; a1 = 10'h010;
        @(posedge clk); #1;
        driveIdle();
        repeat (RD_LAT - 1) @(posedge clk);
        #1;
        checkOutput("retain.valid1", {31'b0, rvalid1}, 32'd1);
        checkOutput("retain.rdata1", rdata1, 32'hDEADBEAA);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
